// File: rtl/psum_line_buffer_pkg.sv
// Shared defaults and pointer arithmetic for the psum line buffer.
// Optional in-buffer accumulation is enabled by defining PSUM_LB_ACC_EN.
package psum_line_buffer_pkg;

   localparam int DATA_WIDTH_DEF  = 16;
   localparam int NUM_CH_DEF      = 3;
   localparam int FIFO_SIZE_DEF   = 10;
   localparam int INDEX_WIDTH_DEF = 4;

   // Wrap: FIFO_SIZE-1 (or a stranded FIFO_SIZE) returns to 0. Saturate: stop at FIFO_SIZE.
   function automatic int unsigned ptr_next(input int unsigned ptr,
                                            input logic        wrap,
                                            input int unsigned size);
      if (wrap) return (ptr >= size - 1) ? 32'd0 : ptr + 32'd1;
      return (ptr >= size) ? size : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/psum_line_buffer_if.sv
// Bus bundle between the PE-row controller (master) and the line buffer (slave).
// acc_en exists only when PSUM_LB_ACC_EN is defined.
interface psum_line_buffer_if
   import psum_line_buffer_pkg::*;
#(
   parameter int NUM_CH      = NUM_CH_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
);

   logic                          wrap_en;
   logic [NUM_CH-1:0]             wr_clr;
   logic [NUM_CH-1:0]             rd_clr;
   logic [NUM_CH-1:0]             wr_en;
   logic [NUM_CH-1:0]             rd_en;
`ifdef PSUM_LB_ACC_EN
   logic [NUM_CH-1:0]             acc_en;
`endif
   logic [NUM_CH*DATA_WIDTH-1:0]  din;
   logic [NUM_CH*DATA_WIDTH-1:0]  dout;
   logic [NUM_CH-1:0]             dout_valid;
   logic [NUM_CH*INDEX_WIDTH-1:0] wr_ptr;
   logic [NUM_CH*INDEX_WIDTH-1:0] rd_ptr;
   logic [NUM_CH-1:0]             wr_done;
   logic [NUM_CH-1:0]             rd_done;
   logic [NUM_CH-1:0]             err_ovf;
   logic [NUM_CH-1:0]             err_udf;

   modport master (
      output wrap_en, wr_clr, rd_clr, wr_en, rd_en,
`ifdef PSUM_LB_ACC_EN
      output acc_en,
`endif
      output din,
      input  dout, dout_valid, wr_ptr, rd_ptr, wr_done, rd_done, err_ovf, err_udf
   );

   modport slave (
      input  wrap_en, wr_clr, rd_clr, wr_en, rd_en,
`ifdef PSUM_LB_ACC_EN
      input  acc_en,
`endif
      input  din,
      output dout, dout_valid, wr_ptr, rd_ptr, wr_done, rd_done, err_ovf, err_udf
   );

endinterface

// File: rtl/psum_line_buffer_chan.sv
// One psum line channel: storage, independent write/read pointers, sticky error flags.
// Accumulate-on-write is added when PSUM_LB_ACC_EN is defined.
module psum_line_chan
   import psum_line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int FIFO_SIZE   = FIFO_SIZE_DEF,
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wrap_en_i,
   input  logic                   wr_clr_i,
   input  logic                   rd_clr_i,
   input  logic                   wr_en_i,
   input  logic                   rd_en_i,
`ifdef PSUM_LB_ACC_EN
   input  logic                   acc_en_i,
`endif
   input  logic [DATA_WIDTH-1:0]  din_i,
   output logic [DATA_WIDTH-1:0]  dout_o,
   output logic                   dout_valid_o,
   output logic [INDEX_WIDTH-1:0] wr_ptr_o,
   output logic [INDEX_WIDTH-1:0] rd_ptr_o,
   output logic                   wr_done_o,
   output logic                   rd_done_o,
   output logic                   err_ovf_o,
   output logic                   err_udf_o
);

   localparam int                     AW      = $clog2(FIFO_SIZE);
   localparam logic [INDEX_WIDTH-1:0] END_PTR = INDEX_WIDTH'(FIFO_SIZE);

   logic [DATA_WIDTH-1:0]  mem_q [FIFO_SIZE];
   logic [INDEX_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [DATA_WIDTH-1:0]  dout_q, dout_d;
   logic                   valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
   logic                   wr_done, rd_done, wr_fire, rd_fire;
   logic [DATA_WIDTH-1:0]  rd_word, wr_word;

   assign wr_done = !wrap_en_i && (wp_q == END_PTR);
   assign rd_done = !wrap_en_i && (rp_q == END_PTR);
   assign wr_fire = wr_en_i && !wr_clr_i && !wr_done;
   assign rd_fire = rd_en_i && !rd_clr_i && !rd_done;

   // A pointer sits at FIFO_SIZE in wrap mode only after an illegal wrap_en change.
   assign rd_word = (rp_q < END_PTR) ? mem_q[AW'(rp_q)] : '0;

`ifdef PSUM_LB_ACC_EN
   assign wr_word = acc_en_i ? (mem_q[AW'(wp_q)] + din_i) : din_i;
`else
   assign wr_word = din_i;
`endif

   always_comb begin
      // NOTE: every next-state value gets a default first so no path infers a latch.
      wp_d    = wp_q;
      ovf_d   = ovf_q;
      rp_d    = rp_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      udf_d   = udf_q;

      if (wr_clr_i)     wp_d  = '0;
      else if (wr_fire) wp_d  = INDEX_WIDTH'(ptr_next(32'(wp_q), wrap_en_i, FIFO_SIZE));
      else if (wr_en_i) ovf_d = 1'b1;

      if (rd_clr_i) begin
         rp_d = '0;
      end else if (rd_fire) begin
         dout_d  = rd_word;
         valid_d = 1'b1;
         rp_d    = INDEX_WIDTH'(ptr_next(32'(rp_q), wrap_en_i, FIFO_SIZE));
      end else if (rd_en_i) begin
         udf_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // NOTE: storage is deliberately left out of reset; the line is always rewritten before use.
   always_ff @(posedge clk) begin
      if (wr_fire && (wp_q < END_PTR)) mem_q[AW'(wp_q)] <= wr_word;
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = valid_q;
   assign wr_ptr_o     = wp_q;
   assign rd_ptr_o     = rp_q;
   assign wr_done_o    = wr_done;
   assign rd_done_o    = rd_done;
   assign err_ovf_o    = ovf_q;
   assign err_udf_o    = udf_q;

endmodule

// File: rtl/psum_line_buffer.sv
// Multi-channel psum line buffer top: NUM_CH independent channels plus bus packing.
// Define PSUM_LB_ACC_EN to add per-channel accumulate-on-write.
module psum_line_buffer
   import psum_line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int NUM_CH      = NUM_CH_DEF,
   parameter int FIFO_SIZE   = FIFO_SIZE_DEF,
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
   input logic               clk,
   input logic               rst,
   psum_line_buffer_if.slave bus
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      psum_line_chan #(
         .DATA_WIDTH  (DATA_WIDTH),
         .FIFO_SIZE   (FIFO_SIZE),
         .INDEX_WIDTH (INDEX_WIDTH)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .wrap_en_i    (bus.wrap_en),
         .wr_clr_i     (bus.wr_clr[c]),
         .rd_clr_i     (bus.rd_clr[c]),
         .wr_en_i      (bus.wr_en[c]),
         .rd_en_i      (bus.rd_en[c]),
`ifdef PSUM_LB_ACC_EN
         .acc_en_i     (bus.acc_en[c]),
`endif
         .din_i        (bus.din[c*DATA_WIDTH +: DATA_WIDTH]),
         .dout_o       (bus.dout[c*DATA_WIDTH +: DATA_WIDTH]),
         .dout_valid_o (bus.dout_valid[c]),
         .wr_ptr_o     (bus.wr_ptr[c*INDEX_WIDTH +: INDEX_WIDTH]),
         .rd_ptr_o     (bus.rd_ptr[c*INDEX_WIDTH +: INDEX_WIDTH]),
         .wr_done_o    (bus.wr_done[c]),
         .rd_done_o    (bus.rd_done[c]),
         .err_ovf_o    (bus.err_ovf[c]),
         .err_udf_o    (bus.err_udf[c])
      );
   end

endmodule

// File: tb/tb_psum_line_buffer.sv
// Self-checking bench for psum_line_buffer: vector table, directed corner sequences,
// and randomized traffic against an array-based reference model.
module tb_psum_line_buffer;

   localparam int DW  = 16;
   localparam int NCH = 3;
   localparam int FS  = 10;
   localparam int IW  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   psum_line_buffer_if #(.NUM_CH(NCH), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

   psum_line_buffer #(.DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_SIZE(FS), .INDEX_WIDTH(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] dout_of(input int c);
      return bus.dout[c*DW +: DW];
   endfunction
   function automatic logic [IW-1:0] wp_of(input int c);
      return bus.wr_ptr[c*IW +: IW];
   endfunction
   function automatic logic [IW-1:0] rp_of(input int c);
      return bus.rd_ptr[c*IW +: IW];
   endfunction

   task automatic idle();
      bus.wr_clr = '0;
      bus.rd_clr = '0;
      bus.wr_en  = '0;
      bus.rd_en  = '0;
      bus.din    = '0;
`ifdef PSUM_LB_ACC_EN
      bus.acc_en = '0;
`endif
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      #2 rst = 1'b1;
      step();
      #2 rst = 1'b0;
      step();
   endtask

   typedef struct {
      logic          wr_en, rd_en, rd_clr;
      logic [DW-1:0] din;
      logic [DW-1:0] exp_dout;
      logic          exp_valid;
      int            exp_wp, exp_rp;
      logic          exp_wdone, exp_rdone, exp_ovf, exp_udf;
   } vec_t;

   function automatic vec_t mk(logic we, logic re, logic rc, int din, int dout, logic vld,
                               int wp, int rp, logic wd, logic rdn, logic ovf, logic udf);
      vec_t v;
      v.wr_en = we; v.rd_en = re; v.rd_clr = rc; v.din = DW'(din);
      v.exp_dout = DW'(dout); v.exp_valid = vld; v.exp_wp = wp; v.exp_rp = rp;
      v.exp_wdone = wd; v.exp_rdone = rdn; v.exp_ovf = ovf; v.exp_udf = udf;
      return v;
   endfunction

   // Reference model state, one entry per channel.
   int unsigned m_mem   [NCH][FS];
   bit          m_known [NCH][FS];
   int          m_wp [NCH];
   int          m_rp [NCH];
   int unsigned m_dout [NCH];
   bit          m_dknown [NCH];
   bit          m_valid [NCH];
   bit          m_ovf [NCH];
   bit          m_udf [NCH];

   function automatic int adv(input int p, input bit wrap);
      if (wrap) return (p + 1) % FS;
      return (p + 1 > FS) ? FS : p + 1;
   endfunction

   vec_t vecs[$];

   initial begin
      bit          r_wclr, r_rclr, r_we, r_re, r_acc, wd, rdn;
      int unsigned r_din;

      idle();
      bus.wrap_en = 1'b0;

      // ---------------- reset state ----------------
      #1 rst = 1'b1;
      #2;
      check("rst.dout",   64'(bus.dout), 64'(0));
      check("rst.valid",  64'(bus.dout_valid), 64'(0));
      check("rst.wr_ptr", 64'(bus.wr_ptr), 64'(0));
      check("rst.rd_ptr", 64'(bus.rd_ptr), 64'(0));
      check("rst.done",   64'({bus.wr_done, bus.rd_done}), 64'(0));
      check("rst.err",    64'({bus.err_ovf, bus.err_udf}), 64'(0));
      step();
      #2 rst = 1'b0;
      step();

      // ---------------- table: saturate fill, read back, overflow, underflow (ch0) ----------------
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(1, 0, 0, i + 1, 0, 0, i + 1, 0, i == 9, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 10, 0, 1, 0, 0, 0));
      for (int i = 1; i <= 10; i++)
         vecs.push_back(mk(0, 1, 0, 0, i, 1, 10, i, 1, i == 10, 0, 0));
      vecs.push_back(mk(1, 0, 0, 99, 10, 0, 10, 10, 1, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 10, 0, 10, 10, 1, 1, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 10, 0, 10, 0, 1, 0, 1, 1));
      for (int i = 1; i <= 10; i++)
         vecs.push_back(mk(0, 1, 0, 0, i, 1, 10, i, 1, i == 10, 1, 1));

      foreach (vecs[i]) begin
         idle();
         bus.wr_en[0]  = vecs[i].wr_en;
         bus.rd_en[0]  = vecs[i].rd_en;
         bus.rd_clr[0] = vecs[i].rd_clr;
         bus.din[0 +: DW] = vecs[i].din;
         step();
         check($sformatf("vec%0d.dout", i),  64'(dout_of(0)), 64'(vecs[i].exp_dout));
         check($sformatf("vec%0d.valid", i), 64'(bus.dout_valid[0]), 64'(vecs[i].exp_valid));
         check($sformatf("vec%0d.wp", i),    64'(wp_of(0)), 64'(vecs[i].exp_wp));
         check($sformatf("vec%0d.rp", i),    64'(rp_of(0)), 64'(vecs[i].exp_rp));
         check($sformatf("vec%0d.wdone", i), 64'(bus.wr_done[0]), 64'(vecs[i].exp_wdone));
         check($sformatf("vec%0d.rdone", i), 64'(bus.rd_done[0]), 64'(vecs[i].exp_rdone));
         check($sformatf("vec%0d.ovf", i),   64'(bus.err_ovf[0]), 64'(vecs[i].exp_ovf));
         check($sformatf("vec%0d.udf", i),   64'(bus.err_udf[0]), 64'(vecs[i].exp_udf));
      end
      idle();

      // ---------------- overlap: read old line while writing new one (ch1) ----------------
      for (int i = 0; i < 10; i++) begin
         idle();
         bus.wr_en[1] = 1'b1;
         bus.din[DW +: DW] = DW'(i + 1);
         step();
      end
      idle();
      bus.wr_clr[1] = 1'b1;
      bus.rd_clr[1] = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         idle();
         bus.wr_en[1] = 1'b1;
         bus.rd_en[1] = 1'b1;
         bus.din[DW +: DW] = DW'(21 + i);
         step();
         check($sformatf("ovl.old%0d", i), 64'(dout_of(1)), 64'(i + 1));
         check($sformatf("ovl.vld%0d", i), 64'(bus.dout_valid[1]), 64'(1));
      end
      idle();
      bus.rd_clr[1] = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         idle();
         bus.rd_en[1] = 1'b1;
         step();
         check($sformatf("ovl.new%0d", i), 64'(dout_of(1)), 64'(21 + i));
      end
      check("ovl.ovf", 64'(bus.err_ovf[1]), 64'(0));

      // ---------------- clear priority over write (ch0) ----------------
      idle();
      bus.wr_en[0]  = 1'b1;
      bus.wr_clr[0] = 1'b1;
      bus.din[0 +: DW] = DW'(55);
      step();
      check("clr.wp", 64'(wp_of(0)), 64'(0));
      idle();
      bus.rd_clr[0] = 1'b1;
      step();
      idle();
      bus.rd_en[0] = 1'b1;
      step();
      check("clr.mem0", 64'(dout_of(0)), 64'(1));
      idle();

      // ---------------- async reset mid-line (ch2 after 4 writes) ----------------
      for (int i = 0; i < 4; i++) begin
         idle();
         bus.wr_en[2] = 1'b1;
         bus.din[2*DW +: DW] = DW'(7 + i);
         step();
      end
      idle();
      check("mid.wp2", 64'(wp_of(2)), 64'(4));
      #2 rst = 1'b1;
      #1;
      check("mid.dout",   64'(bus.dout), 64'(0));
      check("mid.valid",  64'(bus.dout_valid), 64'(0));
      check("mid.wr_ptr", 64'(bus.wr_ptr), 64'(0));
      check("mid.rd_ptr", 64'(bus.rd_ptr), 64'(0));
      check("mid.err",    64'({bus.err_ovf, bus.err_udf}), 64'(0));
      step();
      #2 rst = 1'b0;
      step();

      // ---------------- wrap mode: 13 writes on a 10-entry line (ch0) ----------------
      bus.wrap_en = 1'b1;
      for (int i = 0; i < 13; i++) begin
         idle();
         bus.wr_en[0] = 1'b1;
         bus.din[0 +: DW] = DW'(i + 1);
         step();
         check($sformatf("wrap.wp%0d", i), 64'(wp_of(0)), 64'((i + 1) % FS));
         check($sformatf("wrap.wd%0d", i), 64'(bus.wr_done[0]), 64'(0));
      end
      check("wrap.ovf", 64'(bus.err_ovf[0]), 64'(0));
      for (int i = 0; i < 4; i++) begin
         idle();
         bus.rd_en[0] = 1'b1;
         step();
         check($sformatf("wrap.rd%0d", i), 64'(dout_of(0)), 64'((i < 3) ? 11 + i : 4));
      end
      idle();

      // ---------------- randomized traffic vs reference model ----------------
      for (int phase = 0; phase < 2; phase++) begin
         idle();
         bus.wrap_en = phase[0];
         reset_pulse();
         for (int c = 0; c < NCH; c++) begin
            m_wp[c] = 0; m_rp[c] = 0; m_dout[c] = 0; m_dknown[c] = 1;
            m_valid[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
            for (int k = 0; k < FS; k++) m_known[c][k] = 0;
         end
         for (int n = 0; n < 400; n++) begin
            idle();
            for (int c = 0; c < NCH; c++) begin
               r_wclr = ($urandom_range(15) == 0);
               r_rclr = ($urandom_range(15) == 0);
               r_we   = $urandom_range(1) == 1;
               r_re   = $urandom_range(1) == 1;
               r_din  = $urandom_range(65535);
               r_acc  = 1'b0;
`ifdef PSUM_LB_ACC_EN
               r_acc  = $urandom_range(1) == 1;
               bus.acc_en[c] = r_acc;
`endif
               bus.wr_clr[c] = r_wclr;
               bus.rd_clr[c] = r_rclr;
               bus.wr_en[c]  = r_we;
               bus.rd_en[c]  = r_re;
               bus.din[c*DW +: DW] = DW'(r_din);

               wd  = !phase[0] && (m_wp[c] == FS);
               rdn = !phase[0] && (m_rp[c] == FS);
               if (r_rclr) begin
                  m_rp[c] = 0;
                  m_valid[c] = 0;
               end else if (r_re && !rdn) begin
                  m_dout[c]   = m_mem[c][m_rp[c]];
                  m_dknown[c] = m_known[c][m_rp[c]];
                  m_valid[c]  = 1;
                  m_rp[c]     = adv(m_rp[c], phase[0]);
               end else begin
                  m_valid[c] = 0;
                  if (r_re) m_udf[c] = 1;
               end
               if (r_wclr) begin
                  m_wp[c] = 0;
               end else if (r_we && !wd) begin
                  if (r_acc) begin
                     m_mem[c][m_wp[c]] = (m_mem[c][m_wp[c]] + r_din) % 65536;
                  end else begin
                     m_mem[c][m_wp[c]]   = r_din;
                     m_known[c][m_wp[c]] = 1;
                  end
                  m_wp[c] = adv(m_wp[c], phase[0]);
               end else if (r_we) begin
                  m_ovf[c] = 1;
               end
            end
            step();
            for (int c = 0; c < NCH; c++) begin
               if (m_dknown[c])
                  check($sformatf("rnd%0d.%0d.dout%0d", phase, n, c), 64'(dout_of(c)), 64'(m_dout[c]));
               check($sformatf("rnd%0d.%0d.valid%0d", phase, n, c), 64'(bus.dout_valid[c]), 64'(m_valid[c]));
               check($sformatf("rnd%0d.%0d.wp%0d", phase, n, c),    64'(wp_of(c)), 64'(m_wp[c]));
               check($sformatf("rnd%0d.%0d.rp%0d", phase, n, c),    64'(rp_of(c)), 64'(m_rp[c]));
               check($sformatf("rnd%0d.%0d.wd%0d", phase, n, c),    64'(bus.wr_done[c]),
                     64'(!phase[0] && m_wp[c] == FS));
               check($sformatf("rnd%0d.%0d.rd%0d", phase, n, c),    64'(bus.rd_done[c]),
                     64'(!phase[0] && m_rp[c] == FS));
               check($sformatf("rnd%0d.%0d.ovf%0d", phase, n, c),   64'(bus.err_ovf[c]), 64'(m_ovf[c]));
               check($sformatf("rnd%0d.%0d.udf%0d", phase, n, c),   64'(bus.err_udf[c]), 64'(m_udf[c]));
            end
         end
      end

      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/psum_line_buffer.md
Name: psum_line_buffer

Overview:
Multi-channel partial-sum line buffer that sits between PE rows of the row-stationary conv array. Each of NUM_CH channels stores one line of psums, up to FIFO_SIZE entries. Each channel has independent write and read pointers with separate clear (rewind) controls, so line n+1 can be written while line n is read back. It replaces the single fixed-depth psum FIFOs with a parametrised bank that adds a wrap mode, pointer-status outputs and sticky error flags.

Parameters:
DATA_WIDTH, 16, psum word width
NUM_CH, 3, number of independent line channels
FIFO_SIZE, 10, entries per channel (line length); must be >= 2
INDEX_WIDTH, 4, pointer width; must satisfy 2^INDEX_WIDTH > FIFO_SIZE

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
wrap_en  in  1  1 = pointers wrap to 0 after FIFO_SIZE-1; 0 = pointers saturate at FIFO_SIZE
wr_clr  in  NUM_CH  per-channel synchronous write-pointer rewind
rd_clr  in  NUM_CH  per-channel synchronous read-pointer rewind
wr_en  in  NUM_CH  per-channel write strobe
rd_en  in  NUM_CH  per-channel read strobe
din  in  NUM_CH*DATA_WIDTH  write data; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
dout  out  NUM_CH*DATA_WIDTH  registered read data, same packing as din
dout_valid  out  NUM_CH  dout updated this cycle
wr_ptr  out  NUM_CH*INDEX_WIDTH  current write pointer per channel
rd_ptr  out  NUM_CH*INDEX_WIDTH  current read pointer per channel
wr_done  out  NUM_CH  write pointer == FIFO_SIZE (saturate mode only)
rd_done  out  NUM_CH  read pointer == FIFO_SIZE (saturate mode only)
err_ovf  out  NUM_CH  sticky: write attempted while wr_done
err_udf  out  NUM_CH  sticky: read attempted while rd_done

Behaviour:
- Reset (async, rst=1): all pointers 0; dout 0; dout_valid 0; err_* 0. Storage is not cleared; contents are undefined until written. Reset asserted mid-line aborts the line immediately.
- Channels are fully independent. Per channel, per rising edge:
- Write: if wr_clr, wp<=0 and the write is suppressed, even if wr_en=1. Else if wr_en and !wr_done, mem[wp]<=din and wp advances. Else if wr_en and wr_done, the write is dropped, wp holds and err_ovf<=1.
- Read: if rd_clr, rp<=0, no read is performed and dout_valid<=0. Else if rd_en and !rd_done, dout<=mem[rp], dout_valid<=1 and rp advances. Else if rd_en and rd_done, dout holds, dout_valid<=0 and err_udf<=1. Otherwise dout holds and dout_valid<=0.
- Read latency is 1 cycle: data appears on the edge after the rd_en sample.
- Same-address read and write in one cycle is read-before-write: dout gets the old contents.
- No empty/full coupling between pointers. Reading beyond wp returns stale data and is not an error. Sequencing is the controller's responsibility.
- Saturate mode (wrap_en=0): a pointer advances 0..FIFO_SIZE and stops there; *_done=1 at FIFO_SIZE.
- Wrap mode (wrap_en=1): a pointer at FIFO_SIZE-1 advances to 0. *_done is held 0, so err_* never sets.
- wrap_en changes are legal only while all pointers are below FIFO_SIZE. If wrap_en goes 1 while a pointer sits at FIFO_SIZE, that pointer's next advance goes to 0.
- err_* clear only on rst.
- wr_ptr and rd_ptr are the registered pointer values.

Optional Feature:
PSUM_LB_ACC_EN
- Defined: adds input acc_en[NUM_CH]. When acc_en=1 on a performed write, mem[wp]<=mem[wp]+din, with modulo 2^DATA_WIDTH wrap and no saturation. This enables in-buffer accumulation across kernel rows. Read-before-write ordering is unchanged.
- Undefined: no acc_en port; writes always overwrite.

Decomposition:
- Shared package/header: DATA_WIDTH, FIFO_SIZE and INDEX_WIDTH defaults, plus pointer next-value function (saturate/wrap).
- Sub-module psum_line_chan: one channel (storage, pointers, flags), instantiated NUM_CH times by a generate loop. The top level handles bus packing only.

Test Plan:
1. Saturate mode, ch0: write 1..10 on consecutive cycles, then rd_clr, then rd_en for 10 cycles -> dout 1..10, one cycle after each rd_en, with dout_valid=1. After the writes, wr_done=1 and wr_ptr=10.
2. Overflow/underflow: 11th write (value 99) -> dropped, err_ovf[0]=1, mem unchanged. 11th read -> dout holds 10, dout_valid=0, err_udf[0]=1.
3. Overlap: ch1 holds 1..10. Assert wr_clr and rd_clr, then wr_en and rd_en together with din=20+i -> dout returns the old values 1..10 while the new line is stored. A re-read after rd_clr returns 21..30.
4. Clear priority: wr_en=1 with wr_clr=1 and din=55 -> no write, wp=0; mem[0] keeps its prior value.
5. Wrap mode with FIFO_SIZE=10: 13 writes of values 1..13 -> wp sequence ends at 3, mem[0..2]=11,12,13, wr_done stays 0, no err_ovf.
6. Reset mid-line: rst pulse after 4 writes on ch2 -> all pointers 0, dout 0, and flags 0 immediately, asynchronously. Channels 0 and 1 are equally reset.
